// File: rtl/cursor_overlay_if.sv
// CPU register write port for cursor_overlay: one-cycle write strobe with
// address and data. The CPU side drives (master); the overlay samples (slave).
interface cursor_overlay_if;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cursor_overlay.sv
// cursor_overlay: 16x16, 2-bit-per-pixel hardware cursor overlaid on the
// drawing_vduc pixel stream. Every output is its input delayed one clock.
// Optional feature macro: CURSOR_BLINK_EN (frame-counted blink, ctrl bit1).
module cursor_overlay #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             pixel_in,
  input  logic                   h_blank_in,
  input  logic                   v_blank_in,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  cursor_overlay_if.slave        wr,
  output logic [7:0]             pixel_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   h_blank_out,
  output logic                   v_blank_out
);

`ifdef CURSOR_BLINK_EN
  localparam int CTRL_W = 2;
`else
  localparam int CTRL_W = 1;
`endif
  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  // Position counters stick at full scale instead of wrapping.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  logic              r_vb_prev, r_hb_prev;
  logic [10:0]       r_x, r_y;
  logic [9:0]        r_cx_sh, r_cy_sh, r_cx, r_cy;
  logic [CTRL_W-1:0] r_ctrl_sh, r_ctrl;
  logic [7:0]        r_col1, r_col2;
  logic [31:0]       r_bmp [16];
  logic [7:0]        r_pix_p1;
  logic              r_hs_p1, r_vs_p1, r_hb_p1, r_vb_p1;

  logic        w_vb_rise, w_hb_rise;
  logic        w_wr_cx, w_wr_cy, w_wr_ctrl, w_wr_col, w_wr_bmp;
  logic [3:0]  w_row;
  logic [10:0] w_lx, w_ly;
  logic        w_blink_mask, w_hit;
  logic [31:0] w_row_bits;
  logic [1:0]  w_code;
  logic [7:0]  w_pix_ov;

  assign w_vb_rise = v_blank_in & ~r_vb_prev;
  assign w_hb_rise = h_blank_in & ~r_hb_prev;

  assign w_wr_cx   = wr.wr_en && (wr.wr_addr == 6'd0);
  assign w_wr_cy   = wr.wr_en && (wr.wr_addr == 6'd1);
  assign w_wr_ctrl = wr.wr_en && (wr.wr_addr == 6'd2);
  assign w_wr_col  = wr.wr_en && (wr.wr_addr == 6'd3);
  assign w_wr_bmp  = wr.wr_en && (wr.wr_addr >= 6'd16) && (wr.wr_addr < 6'd48);
  // (addr-16)>>1 for addr in 16..47 reduces to {addr[5], addr[3:1]}.
  assign w_row     = {wr.wr_addr[5], wr.wr_addr[3:1]};

  // Position/control shadows, copied to live registers on a v_blank rise;
  // a write landing on the copy cycle is forwarded straight into live.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cx_sh   <= '0;
      r_cy_sh   <= '0;
      r_ctrl_sh <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_ctrl    <= '0;
    end else begin
      if (w_wr_cx)   r_cx_sh   <= wr.wr_data[9:0];
      if (w_wr_cy)   r_cy_sh   <= wr.wr_data[9:0];
      if (w_wr_ctrl) r_ctrl_sh <= wr.wr_data[CTRL_W-1:0];
      if (w_vb_rise) begin
        r_cx   <= w_wr_cx   ? wr.wr_data[9:0]        : r_cx_sh;
        r_cy   <= w_wr_cy   ? wr.wr_data[9:0]        : r_cy_sh;
        r_ctrl <= w_wr_ctrl ? wr.wr_data[CTRL_W-1:0] : r_ctrl_sh;
      end
    end
  end

  // Colours and bitmap are unshadowed and take effect on the next pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col1 <= '0;
      r_col2 <= '0;
      for (int i = 0; i < 16; i++) r_bmp[i] <= '0;
    end else begin
      if (w_wr_col) begin
        r_col1 <= wr.wr_data[7:0];
        r_col2 <= wr.wr_data[15:8];
      end
      if (w_wr_bmp) begin
        if (wr.wr_addr[0]) r_bmp[w_row][31:16] <= wr.wr_data;
        else               r_bmp[w_row][15:0]  <= wr.wr_data;
      end
    end
  end

  // Raster position tracking from the blank strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vb_prev <= 1'b0;
      r_hb_prev <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vb_prev <= v_blank_in;
      r_hb_prev <= h_blank_in;
      if (h_blank_in)       r_x <= '0;
      else if (!v_blank_in) r_x <= sat_inc(r_x);
      if (v_blank_in)       r_y <= '0;
      else if (w_hb_rise)   r_y <= sat_inc(r_y);
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  logic [FCW-1:0] r_fcnt;
  logic           r_phase;

  // Frame counter toggling the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_vb_rise) begin
      if (r_fcnt == FCW'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt  <= r_fcnt + FCW'(1);
      end
    end
  end

  assign w_blink_mask = r_ctrl[1] & r_phase;
`else
  // No blink hardware; the parameter only exists for a common instance
  // signature, so the mask is a constant false derived from it.
  assign w_blink_mask = (BLINK_FRAMES < 0);
`endif

  // 11-bit offsets; the x >= cx / y >= cy terms reject negative offsets.
  assign w_lx = r_x - {1'b0, r_cx};
  assign w_ly = r_y - {1'b0, r_cy};
  assign w_hit = r_ctrl[0] && !w_blink_mask
              && (r_x >= {1'b0, r_cx}) && (w_lx < 11'd16)
              && (r_y >= {1'b0, r_cy}) && (w_ly < 11'd16)
              && (r_x < H_LIM) && (r_y < V_LIM);

  assign w_row_bits = r_bmp[w_ly[3:0]];
  assign w_code     = w_row_bits[{w_lx[3:0], 1'b0} +: 2];

  // Cursor code to overlay pixel.
  always_comb begin
    w_pix_ov = pixel_in;
    case (w_code)
      2'b01:   w_pix_ov = r_col1;
      2'b10:   w_pix_ov = r_col2;
      2'b11:   w_pix_ov = pixel_in ^ 8'hFF;
      default: w_pix_ov = pixel_in;
    endcase
  end

  // ---- stage p0 -> p1: single output register for pixel and syncs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pix_p1 <= '0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
      r_hb_p1  <= 1'b0;
      r_vb_p1  <= 1'b0;
    end else begin
      r_pix_p1 <= (!h_blank_in && !v_blank_in && w_hit) ? w_pix_ov : pixel_in;
      r_hs_p1  <= h_sync_in;
      r_vs_p1  <= v_sync_in;
      r_hb_p1  <= h_blank_in;
      r_vb_p1  <= v_blank_in;
    end
  end

  assign pixel_out   = r_pix_p1;
  assign h_sync_out  = r_hs_p1;
  assign v_sync_out  = r_vs_p1;
  assign h_blank_out = r_hb_p1;
  assign v_blank_out = r_vb_p1;

endmodule
